// File: rtl/axi_dm_pkg.sv
// Shared types and helpers for the DataMover copy controller.
// Command/status layouts and FSM states live here.
package axi_dm_pkg;

    localparam int CMD_W = 72;

    localparam int STS_OKAY    = 7;
    localparam int STS_SLVERR  = 6;
    localparam int STS_DECERR  = 5;
    localparam int STS_INTERR  = 4;
    localparam int STS_TAG_MSB = 3;

    typedef struct packed {
        logic [3:0]  rsvd;
        logic [3:0]  tag;
        logic [31:0] addr;
        logic        drr;
        logic        eof;
        logic [5:0]  dsa;
        logic        incr;
        logic [22:0] btt;
    } dm_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HALT
    } ctrl_state_e;

    function automatic dm_cmd_t pack_cmd(
        input logic [22:0] btt,
        input logic [31:0] addr,
        input logic [3:0]  tag,
        input logic        eof
    );
        dm_cmd_t c;
        c      = '0;
        c.btt  = btt;
        c.incr = 1'b1;
        c.eof  = eof;
        c.addr = addr;
        c.tag  = tag;
        return c;
    endfunction

endpackage

// File: rtl/axi_dm_copy_ctrl_if.sv
// Job request, completion and DataMover command/status bundle.
// master = controller side, slave = job issuer + DataMover side.
interface axi_dm_copy_ctrl_if;
    import axi_dm_pkg::*;

    logic             job_valid;
    logic             job_ready;
    logic [31:0]      job_src;
    logic [31:0]      job_dst;
    logic [31:0]      job_len;
    logic             busy;
    logic             done;
    logic             done_err;
    logic [7:0]       err_code;
    logic             halted;

    logic             m_axis_mm2s_cmd_tvalid;
    logic             m_axis_mm2s_cmd_tready;
    logic [CMD_W-1:0] m_axis_mm2s_cmd_tdata;
    logic             s_axis_mm2s_sts_tvalid;
    logic             s_axis_mm2s_sts_tready;
    logic [7:0]       s_axis_mm2s_sts_tdata;

    logic             m_axis_s2mm_cmd_tvalid;
    logic             m_axis_s2mm_cmd_tready;
    logic [CMD_W-1:0] m_axis_s2mm_cmd_tdata;
    logic             s_axis_s2mm_sts_tvalid;
    logic             s_axis_s2mm_sts_tready;
    logic [7:0]       s_axis_s2mm_sts_tdata;

    logic             mm2s_err;
    logic             s2mm_err;

    modport master (
        input  job_valid, job_src, job_dst, job_len,
        output job_ready, busy, done, done_err, err_code, halted,
        output m_axis_mm2s_cmd_tvalid, m_axis_mm2s_cmd_tdata,
        input  m_axis_mm2s_cmd_tready,
        input  s_axis_mm2s_sts_tvalid, s_axis_mm2s_sts_tdata,
        output s_axis_mm2s_sts_tready,
        output m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata,
        input  m_axis_s2mm_cmd_tready,
        input  s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata,
        output s_axis_s2mm_sts_tready,
        input  mm2s_err, s2mm_err
    );

    modport slave (
        output job_valid, job_src, job_dst, job_len,
        input  job_ready, busy, done, done_err, err_code, halted,
        input  m_axis_mm2s_cmd_tvalid, m_axis_mm2s_cmd_tdata,
        output m_axis_mm2s_cmd_tready,
        output s_axis_mm2s_sts_tvalid, s_axis_mm2s_sts_tdata,
        input  s_axis_mm2s_sts_tready,
        input  m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata,
        output m_axis_s2mm_cmd_tready,
        output s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata,
        input  s_axis_s2mm_sts_tready,
        output mm2s_err, s2mm_err
    );

endinterface

// File: rtl/axi_dm_sts_tracker.sv
// Per-channel outstanding count, expected tag and status error check.
module axi_dm_sts_tracker
    import axi_dm_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cmd_acc,
    input  logic       sts_acc,
    input  logic [7:0] sts_data,
    output logic       can_issue,
    output logic       empty,
    output logic       err,
    output logic [7:0] err_byte
);
    localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

    logic [3:0] cnt_q;
    logic [3:0] tag_q;
    logic       stray;
    logic       dec;

    assign can_issue = (cnt_q != MAX_O);
    assign empty     = (cnt_q == 4'd0);
    // A status in the same cycle as its command accept is not stray.
    assign stray     = empty & ~cmd_acc;
    assign dec       = sts_acc & ~stray;
    assign err_byte  = sts_data;

    assign err = sts_acc & (~sts_data[STS_OKAY]
               | sts_data[STS_SLVERR]
               | sts_data[STS_DECERR]
               | sts_data[STS_INTERR]
               | (sts_data[STS_TAG_MSB:0] != tag_q)
               | stray);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tag_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
            tag_q <= '0;
        end else begin
            if (sts_acc) begin
                tag_q <= tag_q + 4'd1;
            end
            unique case (1'b1)
                cmd_acc & ~dec: cnt_q <= cnt_q + 4'd1;
                dec & ~cmd_acc: cnt_q <= cnt_q - 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_dm_copy_ctrl.sv
// Splits copy jobs into DataMover command pairs and tracks their status.
module axi_dm_copy_ctrl
    import axi_dm_pkg::*;
#(
    parameter int MAX_CHUNK       = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                m_axi_aclk,
    input logic                m_axi_aresetn,
    axi_dm_copy_ctrl_if.master bus
);
    localparam logic [31:0] CHUNK     = 32'(MAX_CHUNK);
    localparam logic [22:0] CHUNK_BTT = 23'(MAX_CHUNK);

    ctrl_state_e state_q, state_d;

    logic [31:0] src_q, dst_q, rem_q, chunk_q;
    logic        mm2s_vld_q, s2mm_vld_q;
    logic        job_err_q, zero_done_q, sts_rdy_q;
    logic [7:0]  err_code_q;

    logic        mm2s_acc, s2mm_acc, mm2s_sts, s2mm_sts;
    logic        mm2s_can, s2mm_can, mm2s_empty, s2mm_empty;
    logic        mm2s_bad, s2mm_bad;
    logic [7:0]  mm2s_byte, s2mm_byte;
    logic        last_chunk;
    logic [22:0] btt;
    logic        pair_open, pair_done;
    logic        err_now, dm_err, job_acc;
    logic        start, present, advance, drain_done;

    assign mm2s_acc = mm2s_vld_q & bus.m_axis_mm2s_cmd_tready;
    assign s2mm_acc = s2mm_vld_q & bus.m_axis_s2mm_cmd_tready;
    assign mm2s_sts = bus.s_axis_mm2s_sts_tvalid & sts_rdy_q;
    assign s2mm_sts = bus.s_axis_s2mm_sts_tvalid & sts_rdy_q;

    assign last_chunk = (rem_q <= CHUNK);
    assign btt        = last_chunk ? rem_q[22:0] : CHUNK_BTT;

    assign pair_open = mm2s_vld_q | s2mm_vld_q;
    assign pair_done = pair_open
                     & (~mm2s_vld_q | mm2s_acc)
                     & (~s2mm_vld_q | s2mm_acc);

    assign err_now = mm2s_bad | s2mm_bad;
    assign dm_err  = bus.mm2s_err | bus.s2mm_err;
    assign job_acc = bus.job_valid & (state_q == S_IDLE);

    axi_dm_sts_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_mm2s_trk (
        .clk      (m_axi_aclk),
        .rst_n    (m_axi_aresetn),
        .clr      (start),
        .cmd_acc  (mm2s_acc),
        .sts_acc  (mm2s_sts),
        .sts_data (bus.s_axis_mm2s_sts_tdata),
        .can_issue(mm2s_can),
        .empty    (mm2s_empty),
        .err      (mm2s_bad),
        .err_byte (mm2s_byte)
    );

    axi_dm_sts_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_s2mm_trk (
        .clk      (m_axi_aclk),
        .rst_n    (m_axi_aresetn),
        .clr      (start),
        .cmd_acc  (s2mm_acc),
        .sts_acc  (s2mm_sts),
        .sts_data (bus.s_axis_s2mm_sts_tdata),
        .can_issue(s2mm_can),
        .empty    (s2mm_empty),
        .err      (s2mm_bad),
        .err_byte (s2mm_byte)
    );

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        present    = 1'b0;
        advance    = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (job_acc && bus.job_len != 32'd0) begin
                    state_d = S_ISSUE;
                    start   = 1'b1;
                end
            end
            S_ISSUE: begin
                // One idle cycle between pairs re-checks errors and credits.
                if (pair_done) begin
                    advance = 1'b1;
                end else if (!pair_open) begin
                    if (rem_q == 32'd0 || job_err_q || err_now) begin
                        state_d = S_DRAIN;
                    end else if (mm2s_can && s2mm_can) begin
                        present = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (mm2s_empty && s2mm_empty) begin
                    state_d    = S_IDLE;
                    drain_done = 1'b1;
                end
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
        if (dm_err) begin
            state_d = S_HALT;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            mm2s_vld_q  <= 1'b0;
            s2mm_vld_q  <= 1'b0;
            job_err_q   <= 1'b0;
            err_code_q  <= '0;
            zero_done_q <= 1'b0;
            sts_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sts_rdy_q   <= (state_d != S_HALT);
            zero_done_q <= job_acc & (bus.job_len == 32'd0) & ~dm_err;

            if (start) begin
                src_q   <= bus.job_src;
                dst_q   <= bus.job_dst;
                rem_q   <= bus.job_len;
                chunk_q <= '0;
            end else if (advance) begin
                src_q   <= src_q + CHUNK;
                dst_q   <= dst_q + CHUNK;
                rem_q   <= rem_q - {9'd0, btt};
                chunk_q <= chunk_q + 32'd1;
            end

            if (state_d == S_HALT) begin
                mm2s_vld_q <= 1'b0;
                s2mm_vld_q <= 1'b0;
            end else if (start || present) begin
                mm2s_vld_q <= 1'b1;
                s2mm_vld_q <= 1'b1;
            end else begin
                if (mm2s_acc) mm2s_vld_q <= 1'b0;
                if (s2mm_acc) s2mm_vld_q <= 1'b0;
            end

            if (start) begin
                job_err_q  <= 1'b0;
                err_code_q <= '0;
            end else if (err_now && !job_err_q) begin
                job_err_q  <= 1'b1;
                err_code_q <= mm2s_bad ? mm2s_byte : s2mm_byte;
            end
        end
    end

    assign bus.m_axis_mm2s_cmd_tvalid = mm2s_vld_q;
    assign bus.m_axis_s2mm_cmd_tvalid = s2mm_vld_q;
    assign bus.m_axis_mm2s_cmd_tdata  = pack_cmd(btt, src_q, chunk_q[3:0], last_chunk);
    assign bus.m_axis_s2mm_cmd_tdata  = pack_cmd(btt, dst_q, chunk_q[3:0], last_chunk);
    assign bus.s_axis_mm2s_sts_tready = sts_rdy_q;
    assign bus.s_axis_s2mm_sts_tready = sts_rdy_q;

    assign bus.job_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.done      = zero_done_q | drain_done;
    assign bus.done_err  = drain_done & job_err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: doc/axi_dm_copy_ctrl.md
Name: axi_dm_copy_ctrl

Overview:
- Sequences one AXI DataMover instance (MM2S + S2MM engines) to perform memory-to-memory copy jobs.
- Accepts a job (src, dst, byte length) and splits it into chunks of at most MAX_CHUNK bytes.
- Issues a matched 72-bit command pair per chunk, tracks the 8-bit status streams and reports completion or error.
- Sits between the job-issuing logic (register block / sequencer) and the DataMover command/status AXI-Stream ports.

Parameters:
MAX_CHUNK, 4096, bytes per chunk; power of two, 8 to 2^22.
MAX_OUTSTANDING, 4, max commands issued but not yet statused, per channel; 1 to 8.

Ports:
m_axi_aclk  in  1  sole clock
m_axi_aresetn  in  1  asynchronous active-low reset
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_src  in  32  source byte address
job_dst  in  32  destination byte address
job_len  in  32  byte count
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
done_err  out  1  valid with done; 1 = job failed
err_code  out  8  first failing status byte, or 0x00
halted  out  1  DataMover internal error seen; cleared only by reset
m_axis_mm2s_cmd_tvalid / _tready / _tdata  out/in/out  1/1/72  MM2S command stream
s_axis_mm2s_sts_tvalid / _tready / _tdata  in/out/in  1/1/8  MM2S status stream
m_axis_s2mm_cmd_tvalid / _tready / _tdata  out/in/out  1/1/72  S2MM command stream
s_axis_s2mm_sts_tvalid / _tready / _tdata  in/out/in  1/1/8  S2MM status stream
mm2s_err, s2mm_err  in  1  DataMover internal error flags

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0 except job_ready=1.
  - Counters and tags cleared; cmd tvalids drop immediately.
- Command tdata layout:
  - [22:0] BTT; [23] TYPE=1 (INCR); [29:24] DSA=0; [30] EOF; [31] DRR=0.
  - [63:32] address (src for MM2S, dst for S2MM); [67:64] TAG; [71:68]=0.
- Status layout: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG. sts tready=1 in every state except reset/HALT.
- FSM states: IDLE, ISSUE, DRAIN, HALT.
- IDLE:
  - On job_valid & job_ready, latch src/dst/len and set busy.
  - len=0 → done=1, done_err=0 next cycle, no commands issued, stay IDLE.
  - Otherwise → ISSUE; cmd tvalid rises the cycle after accept.
- ISSUE:
  - Chunk k: BTT = min(MAX_CHUNK, remaining); addresses = base + k*MAX_CHUNK, 32-bit wrap.
  - TAG = k mod 16, identical on both channels; EOF=1 only on the last chunk.
  - MM2S and S2MM commands handshake independently. Each tvalid is held with stable tdata until its tready.
  - The next chunk is presented only after both commands of the current chunk are accepted.
  - A chunk is not presented while either channel's outstanding count equals MAX_OUTSTANDING.
  - After the last chunk is fully accepted → DRAIN.
- Status check, per channel:
  - Each status handshake decrements that channel's outstanding count and advances its expected tag (mod 16).
  - Error if OKAY=0, any of [6:4]=1, or TAG ≠ expected.
  - First error latches err_code (MM2S wins on a same-cycle error) and sets sticky job_err.
  - A status arriving with outstanding=0 is an error.
- Error in ISSUE: finish handshaking the current chunk pair, issue no more, → DRAIN.
- DRAIN: when both outstanding counts = 0 → IDLE, done=1 with done_err=job_err, busy=0.
  - done is asserted one cycle after the final status handshake.
- Simultaneous command accept and status on the same channel: outstanding count unchanged.
- mm2s_err or s2mm_err high in any non-reset state:
  - → HALT the next cycle; cmd tvalids=0, job_ready=0, halted=1, busy stays 1.
  - No done pulse; exit only by reset.
- Counts: chunk counter 32 bits; outstanding counters 4 bits.

Decomposition:
- Package axi_dm_pkg:
  - Packed struct dm_cmd_t with the fields above, and a function pack_cmd(btt, addr, tag, eof).
  - Status bit-position localparams and constant CMD_W=72.
- Sub-module axi_dm_sts_tracker, instantiated once per channel:
  - Outstanding counter, expected-tag counter, error detect.
  - Outputs: can_issue, empty, err, err_byte.

Test Plan:
1. src=0x1000_0000, dst=0x2000_0000, len=10000, all OKAY status → 3 pairs; BTT 4096/4096/1808; addresses +0x1000 per chunk; tags 0/1/2; EOF only on chunk 2; done with done_err=0 one cycle after last status.
2. len=0 → no cmd tvalid ever; done=1, done_err=0 the cycle after accept; job_ready stays 1.
3. len=40960, statuses withheld, s2mm cmd tready low 20 cycles → at most 4 pairs issued; chunk 4 waits for the first status pair; MM2S tdata stable while S2MM stalls.
4. len=16384, chunk-1 S2MM status 0x41 (SLVERR, tag 1) → no chunk 2/3 commands after the current pair; done_err=1, err_code=0x41 after drain.
5. First MM2S status 0x83 while expected tag 0 → done_err=1, err_code=0x83.
6. s2mm_err pulse mid-job → halted=1, both cmd tvalid=0, job_ready=0, no done; after reset pulse → job_ready=1, halted=0.
